palette_bank: RTL and testbench
===============================

PALETTE_BANK -- requirements
Module: palette_bank

Interface
REQ-001 Parameter IDX_W, default 4, color-index width; 2**IDX_W entries per palette.
REQ-002 Parameter COMP_W, default 4, width of each of red/green/blue.
REQ-003 Parameter NUM_PAL, default 4, number of independent palettes; PAL_W = max(1, clog2(NUM_PAL)).
REQ-004 Parameter FADE_W, default 4, brightness resolution; level range 0..2**FADE_W.
REQ-005 Parameter TRANSP_IDX, default 0, index value flagged as transparent.
REQ-006 Clk  in  1  sole clock, all state on rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 rd_valid  in  1  read request this cycle.
REQ-009 rd_pal  in  PAL_W  palette select for read.
REQ-010 rd_index  in  IDX_W  color index for read.
REQ-011 out_valid  out  1  red/green/blue/transparent valid.
REQ-012 red, green, blue  out  COMP_W each  scaled color.
REQ-013 transparent  out  1  read index equalled TRANSP_IDX.
REQ-014 wr_en  in  1  write one entry this cycle.
REQ-015 wr_pal  in  PAL_W; wr_index  in  IDX_W; wr_data  in  3*COMP_W  {r,g,b}, red in MSBs.
REQ-016 fade_start  in  1  one-cycle pulse starting a fade.
REQ-017 fade_dir  in  1  0 = fade to black, 1 = fade to full; sampled with fade_start.
REQ-018 fade_div  in  8  cycles per level step minus one; sampled with fade_start.
REQ-019 fade_busy  out  1  fade in progress; fade_done  out  1  one-cycle pulse at fade end.

Function
REQ-020 Read latency SHALL be exactly 2 cycles: request at edge N yields out_valid=1 with data after edge N+2; back-to-back reads every cycle SHALL be supported.
REQ-021 Stage 1 SHALL register the raw entry {r,g,b} from palette rd_pal, entry rd_index, plus the transparent flag and valid.
REQ-022 Stage 2 SHALL output each component = (c * level) >> FADE_W, using the level value current when the stage-2 register loads; level 2**FADE_W SHALL be identity.
REQ-023 out_valid SHALL be 0 in any cycle without a corresponding request; data outputs hold last value when out_valid=0.
REQ-024 Write SHALL commit at the edge where wr_en=1; read and write to the same entry in the same cycle SHALL return the old data (read-before-write).
REQ-025 rd_pal or wr_pal >= NUM_PAL: reads SHALL return all-zero color with transparent still computed; writes SHALL be ignored.
REQ-026 Fade FSM states IDLE and FADING; fade_busy=1 exactly in FADING.
REQ-027 IDLE + fade_start: latch fade_dir, fade_div, load step counter with fade_div, go FADING.
REQ-028 FADING: counter decrements each cycle; at 0, level steps by 1 toward target (0 for dir 0, 2**FADE_W for dir 1) and counter reloads fade_div.
REQ-029 When level reaches target, FSM SHALL return to IDLE and fade_done SHALL pulse for 1 cycle on the same edge.
REQ-030 fade_start while FADING SHALL be ignored.
REQ-031 fade_start when level already equals the target SHALL enter FADING, make no level change, and complete one cycle later with fade_done.

Reset
REQ-032 Reset_n low SHALL asynchronously force: out_valid=0, red/green/blue=0, transparent=0, pipeline valids=0, FSM=IDLE, fade_busy=0, fade_done=0, level=2**FADE_W, step counter=0.
REQ-033 Reset SHALL load every palette entry i with gray ramp: each component = i zero-extended or truncated to COMP_W.
REQ-034 Reset asserted mid-fade or mid-read SHALL abandon the operation; no out_valid or fade_done is produced afterwards for it.

Structure
REQ-035 Shared package palette_pkg SHALL hold the fade state enum and the rgb struct type (COMP_W-parameterised via package constant default 4).
REQ-036 One sub-module, palette_fader, SHALL contain the fade FSM, step counter and level register; the array and read pipeline live in palette_bank.

Verification
REQ-037 After reset, read pal 0 idx 5 (defaults) -> 2 cycles later out_valid=1, rgb={5,5,5}, transparent=0.
REQ-038 Write pal 2 idx 3 = 12'h3CE, read it next cycle -> rgb={3,C,E}; simultaneous write/read same entry -> old {3,3,3}.
REQ-039 Read idx 0 any palette -> transparent=1; rd_pal=4 with NUM_PAL=4 -> rgb=0.
REQ-040 fade_start dir 0, div 0 -> level 16..0 in 16 cycles, fade_done once; read of {F,F,F} at level 8 -> {7,7,7}.
REQ-041 fade_start dir 1 at level 16 -> fade_done 2 cycles after start, level unchanged; second fade_start during FADING ignored.
REQ-042 Reset_n low mid-fade (div 3) -> fade_busy=0, level=16 immediately, no fade_done after release.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and helpers for the palette bank and its fade controller.
package palette_pkg;

    // Default component width used by the rgb struct type.
    localparam int PKG_COMP_W = 4;

    // Fade controller states.
    typedef enum logic [0:0] {
        FADE_IDLE   = 1'b0,
        FADE_FADING = 1'b1
    } fade_state_t;

    // One palette entry, red in the MSBs.
    typedef struct packed {
        logic [PKG_COMP_W-1:0] r;
        logic [PKG_COMP_W-1:0] g;
        logic [PKG_COMP_W-1:0] b;
    } rgb_t;

    // Palette-select width: max(1, clog2(n)).
    function automatic int pal_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/palette_fader.sv
// Fade controller: walks the brightness level one step at a time toward
// black or full scale, pacing each step by a programmable divider.
module palette_fader
    import palette_pkg::*;
#(
    parameter int FADE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fade_start,
    input  logic              i_fade_dir,
    input  logic [7:0]        i_fade_div,
    output logic [FADE_W:0]   o_level,
    output logic              o_fade_busy,
    output logic              o_fade_done
);

    localparam logic [FADE_W:0] LVL_FULL = (FADE_W+1)'(2**FADE_W);
    localparam logic [FADE_W:0] LVL_ZERO = {(FADE_W+1){1'b0}};
    localparam logic [FADE_W:0] LVL_ONE  = {{FADE_W{1'b0}}, 1'b1};

    fade_state_t     r_state, w_state_nxt;
    logic [FADE_W:0] r_level, w_level_nxt, w_target, w_level_step;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [7:0]      r_div, w_div_nxt;
    logic            r_dir, w_dir_nxt;
    logic            r_done, w_done_nxt;

    // Next-state and next-level decisions for the fade sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_cnt_nxt    = r_cnt;
        w_div_nxt    = r_div;
        w_dir_nxt    = r_dir;
        w_done_nxt   = 1'b0;
        w_target     = r_dir ? LVL_FULL : LVL_ZERO;
        w_level_step = r_dir ? (r_level + LVL_ONE) : (r_level - LVL_ONE);
        case (r_state)
            FADE_IDLE: begin
                if (i_fade_start) begin
                    w_state_nxt = FADE_FADING;
                    w_dir_nxt   = i_fade_dir;
                    w_div_nxt   = i_fade_div;
                    w_cnt_nxt   = i_fade_div;
                end else begin
                    w_state_nxt = FADE_IDLE;
                end
            end
            FADE_FADING: begin
                if (r_level == w_target) begin
                    // Already at target: finish without touching the level.
                    w_state_nxt = FADE_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == 8'd0) begin
                    w_level_nxt = w_level_step;
                    w_cnt_nxt   = r_div;
                    if (w_level_step == w_target) begin
                        w_state_nxt = FADE_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FADE_FADING;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = FADE_IDLE;
            end
        endcase
    end

    // Fade state, level, step counter and latched fade parameters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FADE_IDLE;
            r_level <= LVL_FULL;
            r_cnt   <= 8'd0;
            r_div   <= 8'd0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_level     = r_level;
    assign o_fade_busy = (r_state == FADE_FADING);
    assign o_fade_done = r_done;

endmodule

// File: rtl/palette_bank.sv
// Multi-palette color lookup with a two-stage read pipeline whose second
// stage scales each component by the current fade level.
module palette_bank
    import palette_pkg::*;
#(
    parameter  int IDX_W      = 4,
    parameter  int COMP_W     = 4,
    parameter  int NUM_PAL    = 4,
    parameter  int FADE_W     = 4,
    parameter  int TRANSP_IDX = 0,
    localparam int PAL_W      = pal_width(NUM_PAL)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_valid,
    input  logic [PAL_W-1:0]    i_rd_pal,
    input  logic [IDX_W-1:0]    i_rd_index,
    output logic                o_out_valid,
    output logic [COMP_W-1:0]   o_red,
    output logic [COMP_W-1:0]   o_green,
    output logic [COMP_W-1:0]   o_blue,
    output logic                o_transparent,
    input  logic                i_wr_en,
    input  logic [PAL_W-1:0]    i_wr_pal,
    input  logic [IDX_W-1:0]    i_wr_index,
    input  logic [3*COMP_W-1:0] i_wr_data,
    input  logic                i_fade_start,
    input  logic                i_fade_dir,
    input  logic [7:0]          i_fade_div,
    output logic                o_fade_busy,
    output logic                o_fade_done
);

    localparam int DEPTH  = 2**IDX_W;
    localparam int MEM_D  = NUM_PAL * DEPTH;
    localparam int DATA_W = 3 * COMP_W;
    localparam int LVL_W  = FADE_W + 1;

    // c * lvl >> FADE_W; full-scale level returns c unchanged.
    function automatic logic [COMP_W-1:0] scale(input logic [COMP_W-1:0] c,
                                                input logic [LVL_W-1:0]  lvl);
        logic [COMP_W+LVL_W-1:0] p;
        p = {{LVL_W{1'b0}}, c} * {{COMP_W{1'b0}}, lvl};
        return p[FADE_W +: COMP_W];
    endfunction

    logic [DATA_W-1:0]       r_mem [MEM_D];
    logic [PAL_W+IDX_W-1:0]  w_rd_addr, w_wr_addr;
    logic                    w_rd_ok, w_wr_ok, w_rd_transp;
    logic                    r_s1_valid, r_s1_transp;
    logic [DATA_W-1:0]       r_s1_rgb;
    logic [LVL_W-1:0]        w_level;

    // Palette range checks and flat entry addresses ({pal, index}).
    always_comb begin
        w_rd_ok     = ({{(32-PAL_W){1'b0}}, i_rd_pal} < 32'(NUM_PAL));
        w_wr_ok     = ({{(32-PAL_W){1'b0}}, i_wr_pal} < 32'(NUM_PAL));
        w_rd_addr   = {i_rd_pal, i_rd_index};
        w_wr_addr   = {i_wr_pal, i_wr_index};
        w_rd_transp = (i_rd_index == IDX_W'(TRANSP_IDX));
    end

    // Palette storage: gray ramp on reset, single write port otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int a = 0; a < MEM_D; a++) begin
                r_mem[a] <= {3{COMP_W'(a % DEPTH)}};
            end
        end else if (i_wr_en && w_wr_ok) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    // Stage 1: capture raw entry (pre-write contents) and transparency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_rgb    <= {DATA_W{1'b0}};
            r_s1_transp <= 1'b0;
        end else begin
            r_s1_valid <= i_rd_valid;
            if (i_rd_valid) begin
                r_s1_rgb    <= w_rd_ok ? r_mem[w_rd_addr] : {DATA_W{1'b0}};
                r_s1_transp <= w_rd_transp;
            end
        end
    end

    // Stage 2: brightness-scaled outputs; data holds when no result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid   <= 1'b0;
            o_red         <= {COMP_W{1'b0}};
            o_green       <= {COMP_W{1'b0}};
            o_blue        <= {COMP_W{1'b0}};
            o_transparent <= 1'b0;
        end else begin
            o_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_red         <= scale(r_s1_rgb[DATA_W-1 -: COMP_W], w_level);
                o_green       <= scale(r_s1_rgb[2*COMP_W-1 -: COMP_W], w_level);
                o_blue        <= scale(r_s1_rgb[COMP_W-1:0], w_level);
                o_transparent <= r_s1_transp;
            end
        end
    end

    palette_fader #(
        .FADE_W (FADE_W)
    ) u_fader (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_fade_start (i_fade_start),
        .i_fade_dir   (i_fade_dir),
        .i_fade_div   (i_fade_div),
        .o_level      (w_level),
        .o_fade_busy  (o_fade_busy),
        .o_fade_done  (o_fade_done)
    );

endmodule

// File: tb/tb_palette_bank.sv
// Bench for palette_bank: directed scenarios plus random traffic, checked
// against a latency-queue / closed-form-fade reference model.
// NUM_PAL is 3 so that palette select 3 is out of range on the 2-bit port.
module tb_palette_bank;
    import palette_pkg::*;

    localparam int NP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_valid = 1'b0;
    logic [1:0]  rd_pal = 2'd0;
    logic [3:0]  rd_index = 4'd0;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_pal = 2'd0;
    logic [3:0]  wr_index = 4'd0;
    logic [11:0] wr_data = 12'd0;
    logic        fade_start = 1'b0;
    logic        fade_dir = 1'b0;
    logic [7:0]  fade_div = 8'd0;
    logic        fade_busy, fade_done;

    palette_bank #(
        .IDX_W(4), .COMP_W(4), .NUM_PAL(NP), .FADE_W(4), .TRANSP_IDX(0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_valid(rd_valid), .i_rd_pal(rd_pal), .i_rd_index(rd_index),
        .o_out_valid(out_valid), .o_red(red), .o_green(green), .o_blue(blue),
        .o_transparent(transparent),
        .i_wr_en(wr_en), .i_wr_pal(wr_pal), .i_wr_index(wr_index), .i_wr_data(wr_data),
        .i_fade_start(fade_start), .i_fade_dir(fade_dir), .i_fade_div(fade_div),
        .o_fade_busy(fade_busy), .o_fade_done(fade_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct { int due; rgb_t c; bit tr; } rd_t;
    rgb_t m_mem [NP][16];
    rd_t  q[$];
    int   cyc = 0;
    int   f_start, f_l0, f_dir, f_div;
    int   m_level, m_busy, m_done;
    bit   m_out_v, m_out_tr;
    rgb_t m_out_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rgb_t bscale(input rgb_t c, input int lvl);
        rgb_t s;
        s.r = 4'((int'(c.r) * lvl) / 16);
        s.g = 4'((int'(c.g) * lvl) / 16);
        s.b = 4'((int'(c.b) * lvl) / 16);
        return s;
    endfunction

    // Closed-form fade: level/busy/done after edge t for the latest fade.
    task automatic fade_eval(input int t, output int lvl, output int busy, output int done);
        int j, tgt, n, s;
        j   = t - f_start;
        tgt = f_dir ? 16 : 0;
        n   = (tgt > f_l0) ? tgt - f_l0 : f_l0 - tgt;
        if (n == 0) begin
            lvl = f_l0; busy = (j == 0) ? 1 : 0; done = (j == 1) ? 1 : 0;
        end else begin
            s = j / (f_div + 1);
            if (s > n) s = n;
            lvl  = f_dir ? f_l0 + s : f_l0 - s;
            busy = (j < (f_div + 1) * n) ? 1 : 0;
            done = (j == (f_div + 1) * n) ? 1 : 0;
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < 16; i++)
                m_mem[p][i] = '{r: 4'(i), g: 4'(i), b: 4'(i)};
        q.delete();
        f_start = cyc - 1000; f_l0 = 16; f_dir = 1; f_div = 0;
        m_level = 16; m_busy = 0; m_done = 0;
        m_out_v = 1'b0; m_out_tr = 1'b0; m_out_c = '0;
    endtask

    task automatic idle_inputs();
        rd_valid = 1'b0; wr_en = 1'b0; fade_start = 1'b0;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_out_v));
        chk("red", 32'(red), 32'(m_out_c.r));
        chk("green", 32'(green), 32'(m_out_c.g));
        chk("blue", 32'(blue), 32'(m_out_c.b));
        chk("transparent", 32'(transparent), 32'(m_out_tr));
        chk("fade_busy", 32'(fade_busy), 32'(m_busy));
        chk("fade_done", 32'(fade_done), 32'(m_done));
    endtask

    // One clock edge: sample inputs, advance model, compare.
    task automatic step();
        bit rv, wen, fs; int p, ix, wp, wi, fd, fdv, lvl_prev, busy_prev;
        rgb_t wd; rd_t e, r;
        rv = rd_valid; p = rd_pal; ix = rd_index;
        wen = wr_en; wp = wr_pal; wi = wr_index; wd = wr_data;
        fs = fade_start; fd = fade_dir; fdv = fade_div;
        lvl_prev = m_level; busy_prev = m_busy;
        @(posedge clk); #1; cyc++;
        if (fs && busy_prev == 0) begin
            f_start = cyc; f_l0 = lvl_prev; f_dir = fd; f_div = fdv;
        end
        fade_eval(cyc, m_level, m_busy, m_done);
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            m_out_v = 1'b1; m_out_c = bscale(r.c, lvl_prev); m_out_tr = r.tr;
        end else begin
            m_out_v = 1'b0;
        end
        if (rv) begin
            e.due = cyc + 1; e.c = (p < NP) ? m_mem[p][ix] : '0; e.tr = (ix == 0);
            q.push_back(e);
        end
        if (wen && wp < NP) m_mem[wp][wi] = wd;
        compare_all();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0; #1;
        chk("rst_busy", 32'(fade_busy), 32'd0);
        chk("rst_done", 32'(fade_done), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        chk("rst_transp", 32'(transparent), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic read(input int p, input int ix);
        rd_valid = 1'b1; rd_pal = 2'(p); rd_index = 4'(ix);
    endtask

    task automatic write(input int p, input int ix, input logic [11:0] d);
        wr_en = 1'b1; wr_pal = 2'(p); wr_index = 4'(ix); wr_data = d;
    endtask

    initial begin
        int done_cnt;
        model_reset();
        #2;
        do_reset();
        step();

        // Default gray ramp, 2-cycle latency
        read(0, 5); step(); idle_inputs();
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("ramp_valid", 32'(out_valid), 32'd1);
        chk("ramp_rgb", {20'd0, red, green, blue}, 32'h555);
        chk("ramp_transp", 32'(transparent), 32'd0);

        // Write then read; same-cycle read/write returns old data
        write(2, 3, 12'h3CE); step(); idle_inputs();
        read(2, 3); step(); idle_inputs();
        write(1, 3, 12'hABC); read(1, 3); step(); idle_inputs();
        chk("wr_rd_rgb", {20'd0, red, green, blue}, 32'h3CE);
        step();
        chk("rbw_old", {20'd0, red, green, blue}, 32'h333);
        read(1, 3); step(); idle_inputs(); step();
        chk("rbw_new", {20'd0, red, green, blue}, 32'hABC);

        // Transparent index and out-of-range palette (read + write)
        write(3, 7, 12'h123); read(1, 0); step(); idle_inputs();
        read(3, 7); step(); idle_inputs();
        chk("transp_idx0", 32'(transparent), 32'd1);
        step();
        chk("oor_rgb", {20'd0, red, green, blue}, 32'h000);
        chk("oor_transp", 32'(transparent), 32'd0);

        // Fade to black, div 0, with a level-8 read of white
        write(0, 15, 12'hFFF); step(); idle_inputs();
        fade_start = 1'b1; fade_dir = 1'b0; fade_div = 8'd0; step(); idle_inputs();
        done_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) read(0, 15);
            step(); idle_inputs();
            if (fade_done) done_cnt++;
            if (k == 9) chk("fade_l8_red", 32'(red), 32'd7);
        end
        chk("fade_done_once", 32'(done_cnt), 32'd1);
        chk("fade_idle", 32'(fade_busy), 32'd0);

        // Fade up with an ignored mid-fade start, then start at target
        fade_start = 1'b1; fade_dir = 1'b1; fade_div = 8'd0; step(); idle_inputs();
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin fade_start = 1'b1; fade_dir = 1'b0; fade_div = 8'd5; end
            step(); idle_inputs();
        end
        fade_start = 1'b1; fade_dir = 1'b1; step(); idle_inputs();
        chk("at_target_busy", 32'(fade_busy), 32'd1);
        step();
        chk("at_target_done", 32'(fade_done), 32'd1);
        read(0, 15); step(); idle_inputs(); step();
        chk("full_level_red", 32'(red), 32'hF);

        // Reset mid-fade
        fade_start = 1'b1; fade_dir = 1'b0; fade_div = 8'd3; step(); idle_inputs();
        for (int k = 0; k < 6; k++) step();
        read(0, 9); step();
        #2;
        do_reset();
        for (int k = 0; k < 20; k++) step();
        read(0, 15); step(); idle_inputs(); step();
        chk("post_rst_level", 32'(red), 32'hF);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rd_valid = ($urandom_range(0, 2) != 0);
            rd_pal = 2'($urandom_range(0, 3)); rd_index = 4'($urandom_range(0, 15));
            wr_en = ($urandom_range(0, 2) == 0);
            wr_pal = 2'($urandom_range(0, 3)); wr_index = 4'($urandom_range(0, 15));
            wr_data = 12'($urandom);
            fade_start = ($urandom_range(0, 19) == 0);
            fade_dir = 1'($urandom_range(0, 1)); fade_div = 8'($urandom_range(0, 2));
            step();
        end
        idle_inputs();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
